// File: rtl/hawk_axi_owner_arb.sv
// Memory-controller ownership arbiter between HAWK (mstr0) and CPU (mstr1).
// Tracks outstanding AXI traffic and only switches the xbar when it is drained.
module hawk_axi_owner_arb #(
    parameter int MAX_OUTST = 8,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hawk_req,
    input  logic axi_awvalid,
    input  logic axi_awready,
    input  logic axi_wvalid,
    input  logic axi_wready,
    input  logic axi_wlast,
    input  logic axi_bvalid,
    input  logic axi_bready,
    input  logic axi_arvalid,
    input  logic axi_arready,
    input  logic axi_rvalid,
    input  logic axi_rready,
    input  logic axi_rlast,
    output logic mstr_sel,
    output logic hawk_gnt,
    output logic hold_cpu,
    output logic aw_allow,
    output logic ar_allow,
    output logic busy,
    output logic err_underflow
);

    typedef enum logic [1:0] {
        CPU_OWN,
        DRAIN_TO_HAWK,
        HAWK_OWN,
        DRAIN_TO_CPU
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_OUTST);

    state_t state, state_nxt;

    logic [CNT_W-1:0] wr_outst, wdat_outst, rd_outst;
    logic [CNT_W:0]   wr_step, wdat_step, rd_step;
    logic ev_aw, ev_wlast, ev_b, ev_ar, ev_rlast;
    logic all_zero, stable;

    // Returns {underflow, next_count}; saturates high, clamps at zero.
    function automatic logic [CNT_W:0] step_cnt(
        input logic [CNT_W-1:0] c,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W:0] r;
        r = {1'b0, c};
        if (inc && !dec) begin
            if (c != CNT_MAX) r = {1'b0, c + CNT_W'(1)};
        end else if (dec && !inc) begin
            if (c == '0) r[CNT_W] = 1'b1;
            else         r = {1'b0, c - CNT_W'(1)};
        end
        return r;
    endfunction

    assign ev_aw    = axi_awvalid & axi_awready;
    assign ev_wlast = axi_wvalid & axi_wready & axi_wlast;
    assign ev_b     = axi_bvalid & axi_bready;
    assign ev_ar    = axi_arvalid & axi_arready;
    assign ev_rlast = axi_rvalid & axi_rready & axi_rlast;

    assign wr_step   = step_cnt(wr_outst, ev_aw, ev_b);
    assign wdat_step = step_cnt(wdat_outst, ev_aw, ev_wlast);
    assign rd_step   = step_cnt(rd_outst, ev_ar, ev_rlast);

    assign all_zero = (wr_outst == '0) && (wdat_outst == '0) && (rd_outst == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= CPU_OWN;
            wr_outst      <= '0;
            wdat_outst    <= '0;
            rd_outst      <= '0;
            err_underflow <= 1'b0;
        end else begin
            state         <= state_nxt;
            wr_outst      <= wr_step[CNT_W-1:0];
            wdat_outst    <= wdat_step[CNT_W-1:0];
            rd_outst      <= rd_step[CNT_W-1:0];
            err_underflow <= err_underflow | wr_step[CNT_W]
                           | wdat_step[CNT_W] | rd_step[CNT_W];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CPU_OWN: begin
                if (hawk_req) state_nxt = DRAIN_TO_HAWK;
            end
            DRAIN_TO_HAWK: begin
                if (!hawk_req)     state_nxt = CPU_OWN;
                else if (all_zero) state_nxt = HAWK_OWN;
            end
            HAWK_OWN: begin
                if (!hawk_req) state_nxt = DRAIN_TO_CPU;
            end
            DRAIN_TO_CPU: begin
                if (hawk_req)      state_nxt = HAWK_OWN;
                else if (all_zero) state_nxt = CPU_OWN;
            end
            default: state_nxt = CPU_OWN;
        endcase
    end

    // New issue is only admitted while ownership is settled.
    assign stable   = (state == CPU_OWN) || (state == HAWK_OWN);
    assign mstr_sel = !((state == HAWK_OWN) || (state == DRAIN_TO_CPU));
    assign hawk_gnt = (state == HAWK_OWN);
    assign hold_cpu = (state != CPU_OWN);
    assign aw_allow = stable && (wr_outst < LIMIT) && (wdat_outst < LIMIT);
    assign ar_allow = stable && (rd_outst < LIMIT);
    assign busy     = !all_zero;

endmodule

// File: tb/tb_hawk_axi_owner_arb.sv
// Randomized bench for hawk_axi_owner_arb against an ownership/occupancy model.
module tb_hawk_axi_owner_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hawk_req = 1'b0;
    logic axi_awvalid = 1'b0, axi_awready = 1'b0;
    logic axi_wvalid = 1'b0, axi_wready = 1'b0, axi_wlast = 1'b0;
    logic axi_bvalid = 1'b0, axi_bready = 1'b0;
    logic axi_arvalid = 1'b0, axi_arready = 1'b0;
    logic axi_rvalid = 1'b0, axi_rready = 1'b0, axi_rlast = 1'b0;
    logic mstr_sel, hawk_gnt, hold_cpu, aw_allow, ar_allow, busy, err_underflow;

    int n_chk = 0;
    int n_err = 0;

    // Model: who the xbar points at, whether a handover is pending, occupancies.
    bit m_hawk, m_pend, m_err;
    int m_wr, m_wd, m_rd;

    always #5 clk = ~clk;

    hawk_axi_owner_arb #(.MAX_OUTST(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .hawk_req(hawk_req),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rlast(axi_rlast),
        .mstr_sel(mstr_sel), .hawk_gnt(hawk_gnt), .hold_cpu(hold_cpu),
        .aw_allow(aw_allow), .ar_allow(ar_allow), .busy(busy),
        .err_underflow(err_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int occ(input int v, input bit up, input bit dn,
                               inout bit err);
        int r;
        r = v + int'(up) - int'(dn);
        if (r < 0) begin
            r = 0;
            err = 1'b1;
        end
        if (r > 15) r = 15;
        return r;
    endfunction

    task automatic model_reset();
        m_hawk = 0; m_pend = 0; m_err = 0;
        m_wr = 0; m_wd = 0; m_rd = 0;
    endtask

    task automatic model_edge();
        bit aw, wl, b, ar, rl, idle;
        aw = axi_awvalid & axi_awready;
        wl = axi_wvalid & axi_wready & axi_wlast;
        b  = axi_bvalid & axi_bready;
        ar = axi_arvalid & axi_arready;
        rl = axi_rvalid & axi_rready & axi_rlast;
        idle = (m_wr == 0) && (m_wd == 0) && (m_rd == 0);
        if (!m_pend) m_pend = (hawk_req != m_hawk);
        else if (hawk_req == m_hawk) m_pend = 0;
        else if (idle) begin
            m_hawk = hawk_req;
            m_pend = 0;
        end
        m_wr = occ(m_wr, aw, b, m_err);
        m_wd = occ(m_wd, aw, wl, m_err);
        m_rd = occ(m_rd, ar, rl, m_err);
    endtask

    task automatic check_outs(input string ctx);
        chk({ctx, ".mstr_sel"}, mstr_sel, !m_hawk);
        chk({ctx, ".hawk_gnt"}, hawk_gnt, m_hawk && !m_pend);
        chk({ctx, ".hold_cpu"}, hold_cpu, m_hawk || m_pend);
        chk({ctx, ".aw_allow"}, aw_allow, !m_pend && m_wr < 8 && m_wd < 8);
        chk({ctx, ".ar_allow"}, ar_allow, !m_pend && m_rd < 8);
        chk({ctx, ".busy"}, busy, (m_wr | m_wd | m_rd) != 0);
        chk({ctx, ".err"}, err_underflow, m_err);
    endtask

    task automatic idle_in();
        {axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast} = '0;
        {axi_bvalid, axi_bready, axi_arvalid, axi_arready} = '0;
        {axi_rvalid, axi_rready, axi_rlast} = '0;
    endtask

    task automatic cycle(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_outs(ctx);
    endtask

    task automatic do_reset(input string ctx);
        idle_in();
        hawk_req = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check_outs(ctx);
        #2 rst = 1'b0;
    endtask

    task automatic ev(input bit aw, input bit wl, input bit b,
                      input bit ar, input bit rl);
        idle_in();
        axi_awvalid = aw; axi_awready = aw;
        axi_wvalid = wl; axi_wready = wl; axi_wlast = wl;
        axi_bvalid = b; axi_bready = b;
        axi_arvalid = ar; axi_arready = ar;
        axi_rvalid = rl; axi_rready = rl; axi_rlast = rl;
    endtask

    initial begin
        int p_inc, p_dec;
        model_reset();
        #1 check_outs("por");
        @(posedge clk);
        #1 rst = 1'b0;

        // idle switch latency
        hawk_req = 1'b1;
        cycle("lat1");
        chk("lat1_gnt", hawk_gnt, 1'b0);
        cycle("lat2");
        chk("lat2_gnt", hawk_gnt, 1'b1);
        chk("lat2_sel", mstr_sel, 1'b0);
        hawk_req = 1'b0;
        cycle("back1");
        cycle("back2");

        // drain before handover
        ev(1, 0, 0, 1, 0); cycle("d_aw1");
        ev(1, 0, 0, 0, 0); cycle("d_aw2");
        idle_in(); hawk_req = 1'b1; cycle("d_req");
        chk("d_awallow", aw_allow, 1'b0);
        chk("d_arallow", ar_allow, 1'b0);
        ev(0, 0, 1, 0, 0); cycle("d_b1");
        ev(0, 1, 1, 0, 0); cycle("d_b2");
        ev(0, 1, 0, 0, 1); cycle("d_last");
        chk("d_sel_hold", mstr_sel, 1'b1);
        idle_in(); cycle("d_own");
        chk("d_gnt", hawk_gnt, 1'b1);
        hawk_req = 1'b0;
        cycle("d_rel1");
        cycle("d_rel2");

        // outstanding limit
        for (int i = 0; i < 8; i++) begin
            ev(1, 1, 0, 0, 0);
            cycle("lim_fill");
        end
        chk("lim_full", aw_allow, 1'b0);
        ev(0, 0, 1, 0, 0); cycle("lim_b");
        chk("lim_b_allow", aw_allow, 1'b1);
        ev(1, 1, 1, 0, 0); cycle("lim_same");
        chk("lim_same_allow", aw_allow, 1'b1);
        ev(1, 1, 0, 0, 0); cycle("lim_refill");
        chk("lim_refull", aw_allow, 1'b0);
        for (int i = 0; i < 8; i++) begin
            ev(0, 0, 1, 0, 0);
            cycle("lim_drain");
        end
        chk("lim_idle", busy, 1'b0);

        // abort during drain
        ev(0, 0, 0, 1, 0); cycle("ab_ar1");
        cycle("ab_ar2");
        idle_in(); hawk_req = 1'b1; cycle("ab_req");
        hawk_req = 1'b0; cycle("ab_drop");
        chk("ab_hold", hold_cpu, 1'b0);
        chk("ab_busy", busy, 1'b1);
        ev(0, 0, 0, 0, 1); cycle("ab_r1");
        cycle("ab_r2");
        chk("ab_idle", busy, 1'b0);

        // underflow, then reset mid drain-to-cpu
        ev(0, 0, 1, 0, 0); cycle("uf_b");
        chk("uf_err", err_underflow, 1'b1);
        idle_in(); cycle("uf_sticky");
        hawk_req = 1'b1; cycle("rd_h1"); cycle("rd_h2");
        ev(0, 0, 0, 1, 0); cycle("rd_ar");
        idle_in(); hawk_req = 1'b0; cycle("rd_dtc");
        chk("rd_dtc_sel", mstr_sel, 1'b0);
        do_reset("rst_mid");
        chk("rst_sel", mstr_sel, 1'b1);

        // randomized traffic with shifting bias
        p_inc = 50; p_dec = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                p_inc = int'($urandom_range(10, 90));
                p_dec = int'($urandom_range(10, 90));
            end
            if ($urandom_range(0, 599) == 0) begin
                do_reset("rnd_rst");
            end else begin
                if ($urandom_range(0, 9) == 0) hawk_req = ~hawk_req;
                axi_awvalid = $urandom_range(0, 99) < p_inc;
                axi_awready = $urandom_range(0, 99) < 80;
                axi_wvalid  = $urandom_range(0, 99) < p_dec;
                axi_wready  = $urandom_range(0, 99) < 80;
                axi_wlast   = $urandom_range(0, 99) < 60;
                axi_bvalid  = $urandom_range(0, 99) < p_dec;
                axi_bready  = $urandom_range(0, 99) < 80;
                axi_arvalid = $urandom_range(0, 99) < p_inc;
                axi_arready = $urandom_range(0, 99) < 80;
                axi_rvalid  = $urandom_range(0, 99) < p_dec;
                axi_rready  = $urandom_range(0, 99) < 80;
                axi_rlast   = $urandom_range(0, 99) < 60;
                cycle("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
